// File: rtl/mvu_pe_acc.sv
// mvu_pe_acc: accumulates SF signed adder-tree partial sums into one
// TAcc-wide dot-product result and hands it downstream through a single
// valid/ready holding register.
module mvu_pe_acc #(
    parameter  int TDst_I = 16,
    parameter  int TAcc   = 24,
    parameter  int SF     = 4,
    localparam int FW     = (SF > 1) ? $clog2(SF) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [TDst_I-1:0] in_add,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [TAcc-1:0]   out_acc,
    output logic [FW-1:0]     fold_idx
);

    localparam logic [FW-1:0] LAST_IDX = FW'(SF - 1);

    logic [TAcc-1:0] acc_q, acc_d;
    logic [TAcc-1:0] out_acc_q, out_acc_d;
    logic            out_valid_q, out_valid_d;
    logic [FW-1:0]   fold_q, fold_d;

    logic [TAcc-1:0] add_ext;
    logic [TAcc-1:0] sum;
    logic            last_beat;
    logic            in_fire;
    logic            out_fire;

    // Only the closing beat of a fold needs the holding register, so earlier
    // beats keep flowing while a finished result waits for downstream.
    assign last_beat = (fold_q == LAST_IDX);
    assign in_ready  = !last_beat || !out_valid_q || out_ready;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid_q && out_ready;

    // Two's-complement wrap is intended; no saturation.
    assign add_ext = TAcc'($signed(in_add));
    assign sum     = acc_q + add_ext;

    // Next-state: draining clears out_valid unless a final beat refills it
    // in the same cycle (back-to-back results without a bubble).
    always_comb begin
        acc_d       = acc_q;
        out_acc_d   = out_acc_q;
        out_valid_d = out_valid_q;
        fold_d      = fold_q;
        if (out_fire) begin
            out_valid_d = 1'b0;
        end
        if (in_fire) begin
            if (last_beat) begin
                out_acc_d   = sum;
                out_valid_d = 1'b1;
                acc_d       = '0;
                fold_d      = '0;
            end else begin
                acc_d  = sum;
                fold_d = fold_q + FW'(1);
            end
        end
    end

    // State registers; reset drops any partial fold and any undelivered result.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc_q       <= '0;
            out_acc_q   <= '0;
            out_valid_q <= 1'b0;
            fold_q      <= '0;
        end else begin
            acc_q       <= acc_d;
            out_acc_q   <= out_acc_d;
            out_valid_q <= out_valid_d;
            fold_q      <= fold_d;
        end
    end

    assign out_acc   = out_acc_q;
    assign out_valid = out_valid_q;
    assign fold_idx  = fold_q;

endmodule

// File: tb/tb_mvu_pe_acc.sv
// Bench for mvu_pe_acc: scoreboarded default instance plus small wrap and
// SF=1 instances driven with directed sequences.
module tb_mvu_pe_acc;

    localparam int TD = 16;
    localparam int TA = 24;
    localparam int NF = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // ---------------- default instance ----------------
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [TD-1:0] in_add = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [TA-1:0] out_acc;
    logic [1:0]    fold_idx;

    mvu_pe_acc #(.TDst_I(TD), .TAcc(TA), .SF(NF)) u_dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_add(in_add),
        .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc),
        .fold_idx(fold_idx)
    );

    // ---------------- wrap instance: 8-bit everything ----------------
    logic       w_valid = 1'b0;
    logic       w_ready;
    logic [7:0] w_add = '0;
    logic       w_out_valid;
    logic [7:0] w_out_acc;
    logic [1:0] w_fold;

    mvu_pe_acc #(.TDst_I(8), .TAcc(8), .SF(4)) u_wrap (
        .clock(clock), .reset(reset),
        .in_valid(w_valid), .in_ready(w_ready), .in_add(w_add),
        .out_valid(w_out_valid), .out_ready(1'b1), .out_acc(w_out_acc),
        .fold_idx(w_fold)
    );

    // ---------------- SF=1 instance ----------------
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [TD-1:0] s_add = '0;
    logic          s_out_valid;
    logic [TA-1:0] s_out_acc;
    logic [0:0]    s_fold;

    mvu_pe_acc #(.TDst_I(TD), .TAcc(TA), .SF(1)) u_sf1 (
        .clock(clock), .reset(reset),
        .in_valid(s_valid), .in_ready(s_ready), .in_add(s_add),
        .out_valid(s_out_valid), .out_ready(1'b1), .out_acc(s_out_acc),
        .fold_idx(s_fold)
    );

    // ---------------- reference model + monitor ----------------
    // beats: partial sums accepted so far in the open fold.
    // expq:  results produced but not yet taken by downstream.
    longint        beats[$];
    logic [TA-1:0] expq[$];

    always @(negedge clock) begin
        if (reset) begin
            beats.delete();
            expq.delete();
            chk("rst_out_valid", longint'(out_valid), 0);
            chk("rst_out_acc", longint'(out_acc), 0);
            chk("rst_fold_idx", longint'(fold_idx), 0);
            chk("rst_in_ready", longint'(in_ready), 1);
        end else begin
            chk("fold_idx", longint'(fold_idx), longint'(beats.size()));
            chk("out_valid", longint'(out_valid), longint'(expq.size() != 0));
            chk("in_ready", longint'(in_ready),
                longint'((beats.size() != NF - 1) || (expq.size() == 0) || out_ready));
            if (out_valid && expq.size() != 0) begin
                chk("out_acc", longint'(out_acc), longint'(expq[0]));
                if (out_ready) void'(expq.pop_front());
            end
            if (in_valid && in_ready) begin
                beats.push_back(longint'($signed(in_add)));
                if (beats.size() == NF) begin
                    longint s;
                    s = 0;
                    foreach (beats[k]) s += beats[k];
                    expq.push_back(TA'(s));
                    beats.delete();
                end
            end
        end
    end

    // Offer one beat and hold it until accepted; returns at posedge+1.
    task automatic send(input int v);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_add   = TD'(v);
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clock);
            ok = in_ready;
            @(posedge clock);
            #1;
        end
        if (!ok) chk("send_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        // basic fold 1..4
        out_ready = 1'b1;
        send(1); send(2); send(3); send(4);
        in_valid = 1'b0;
        chk("basic_valid", longint'(out_valid), 1);
        chk("basic_acc", longint'(out_acc), 10);
        idle(1);
        chk("basic_drained", longint'(out_valid), 0);

        // signed values
        send(-5); send(-5); send(7); send(-1);
        in_valid = 1'b0;
        chk("signed_acc", longint'(out_acc), longint'(24'hFFFFFC));
        idle(2);

        // backpressure
        send(1); send(2); send(3);
        out_ready = 1'b0;
        send(4);
        send(1); send(1); send(1);
        in_valid = 1'b1;
        in_add   = TD'(1);
        @(negedge clock);
        chk("bp_in_ready", longint'(in_ready), 0);
        chk("bp_fold_idx", longint'(fold_idx), 3);
        @(negedge clock);
        chk("bp_hold_acc", longint'(out_acc), 10);
        chk("bp_hold_valid", longint'(out_valid), 1);
        @(posedge clock);
        #1 out_ready = 1'b1;
        send(1);
        in_valid = 1'b0;
        chk("bp_next_acc", longint'(out_acc), 4);
        chk("bp_next_valid", longint'(out_valid), 1);
        idle(2);

        // wrap instance: 127 x4 in 8 bits
        for (int i = 0; i < 4; i++) begin
            w_valid = 1'b1;
            w_add   = 8'd127;
            @(negedge clock);
            chk("wrap_in_ready", longint'(w_ready), 1);
            @(posedge clock);
            #1;
        end
        w_valid = 1'b0;
        chk("wrap_acc", longint'(w_out_acc), longint'(8'hFC));
        chk("wrap_valid", longint'(w_out_valid), 1);

        // reset mid-fold
        send(9); send(9);
        in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        chk("rst_mid_valid", longint'(out_valid), 0);
        @(posedge clock);
        #1 reset = 1'b0;
        send(1); send(1); send(1); send(1);
        in_valid = 1'b0;
        chk("rst_mid_acc", longint'(out_acc), 4);
        idle(2);

        // SF=1 streaming 0..99, result must follow one cycle later with no gaps
        for (int i = 0; i < 100; i++) begin
            s_valid = 1'b1;
            s_add   = TD'(i);
            @(posedge clock);
            #1;
            chk("sf1_valid", longint'(s_out_valid), 1);
            chk("sf1_acc", longint'(s_out_acc), longint'(i));
            chk("sf1_fold", longint'(s_fold), 0);
            chk("sf1_ready", longint'(s_ready), 1);
        end
        s_valid = 1'b0;

        // random soak
        for (int c = 0; c < 10000; c++) begin
            in_valid  = ($urandom_range(0, 99) < 60);
            out_ready = ($urandom_range(0, 99) < 55);
            in_add    = TD'($urandom);
            @(posedge clock);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        idle(3);
        chk("drain_empty", longint'(expq.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
